// File: rtl/mbc_mapper_if.sv
// Synchronised cartridge bus as seen by the mapper.
// The cartridge side drives; the mapper only listens.
interface mbc_mapper_if;
  logic [15:0] bus_A_s;
  logic [7:0]  bus_D_in_s;
  logic        bus_nWR;
  logic        bus_nRD;

  modport master (
    output bus_A_s, bus_D_in_s, bus_nWR, bus_nRD
  );

  modport slave (
    input bus_A_s, bus_D_in_s, bus_nWR, bus_nRD
  );
endinterface

// File: rtl/mbc_mapper.sv
// Selectable MBC1/MBC5 bank controller between the cartridge
// bus and the ROM/RAM SPRAM arrays.
module mbc_mapper #(
  parameter int MODE          = 0,
  parameter int ROM_BANK_BITS = 5,
  parameter int RAM_BANK_BITS = 2,
  parameter int SYNC_STAGES   = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       enable,
  mbc_mapper_if.slave                bus,
  output logic [ROM_BANK_BITS+13:0]  rom_addr,
  output logic [RAM_BANK_BITS+12:0]  ram_addr,
  output logic                       ram_we,
  output logic                       cart_oe,
  output logic [ROM_BANK_BITS-1:0]   rom_bank,
  output logic                       ram_enabled
);

  logic [SYNC_STAGES-1:0] nwr_sync;
  logic                   wr_edge;
  logic                   wr_en;
  logic [15:0]            a;
  logic [7:0]             d;
  logic                   in_ram;
  logic [8:0]             bank_full;
  logic [8:0]             zero_full;
  logic [3:0]             rbank_full;
  logic [ROM_BANK_BITS-1:0] rom_field;

  assign a      = bus.bus_A_s;
  assign d      = bus.bus_D_in_s;
  assign wr_en  = wr_edge & enable;
  assign in_ram = (a[15:13] == 3'b101);

  // Reloading with 1s means an in-flight write is dropped on reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      nwr_sync <= '1;
      wr_edge  <= 1'b0;
    end else begin
      nwr_sync <= {nwr_sync[SYNC_STAGES-2:0], bus.bus_nWR};
      wr_edge  <= ~nwr_sync[SYNC_STAGES-1] & nwr_sync[SYNC_STAGES-2];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ram_enabled <= 1'b0;
      ram_we      <= 1'b0;
      cart_oe     <= 1'b0;
    end else begin
      if (wr_en && a[15:13] == 3'b000)
        ram_enabled <= (d[3:0] == 4'hA);
      ram_we  <= wr_en & in_ram & ram_enabled;
      cart_oe <= ~bus.bus_nRD &
                 (~a[15] | (in_ram & ram_enabled));
    end
  end

  if (MODE == 0) begin : g_mbc1
    logic [4:0] lo5;
    logic [1:0] hi2;
    logic       mode_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        lo5    <= 5'd1;
        hi2    <= 2'd0;
        mode_q <= 1'b0;
      end else if (wr_en && !a[15]) begin
        unique case (a[14:13])
          2'b00: ;
          2'b01: lo5 <= (d[4:0] == 5'd0) ? 5'd1 : d[4:0];
          2'b10: hi2 <= d[1:0];
          2'b11: mode_q <= d[0];
        endcase
      end
    end

    assign bank_full  = {2'b00, hi2, lo5};
    assign zero_full  = mode_q ? {2'b00, hi2, 5'd0} : 9'd0;
    assign rbank_full = mode_q ? {2'b00, hi2} : 4'd0;
  end else begin : g_mbc5
    logic [8:0] bank;
    logic [3:0] rbank;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        bank  <= 9'd1;
        rbank <= 4'd0;
      end else if (wr_en) begin
        unique case (1'b1)
          a[15:12] == 4'h2:   bank[7:0] <= d;
          a[15:12] == 4'h3:   bank[8]   <= d[0];
          a[15:13] == 3'b010: rbank     <= d[3:0];
          default: ;
        endcase
      end
    end

    assign bank_full  = bank;
    assign zero_full  = 9'd0;
    assign rbank_full = rbank;
  end

  assign rom_bank  = bank_full[ROM_BANK_BITS-1:0];
  assign rom_field = (a[15:14] == 2'b00) ?
                     zero_full[ROM_BANK_BITS-1:0] : rom_bank;
  assign rom_addr  = {rom_field, a[13:0]};

  if (RAM_BANK_BITS == 0) begin : g_ram_flat
    assign ram_addr = a[12:0];
  end else begin : g_ram_bank
    assign ram_addr = {rbank_full[RAM_BANK_BITS-1:0], a[12:0]};
  end

  logic unused;
  assign unused = ^{bank_full, zero_full, rbank_full, d};

endmodule

// File: tb/tb_mbc_mapper.sv
// Directed bench for mbc_mapper: MBC1 and MBC5 instances share one bus;
// RAM write pulses are checked by a scoreboard monitor.
module tb_mbc_mapper;

  localparam int S = 4;

  logic clk;
  logic reset_n;
  logic enable;

  mbc_mapper_if bus();

  logic [20:0] rom1;
  logic [14:0] ram1;
  logic        we1, oe1, en1;
  logic [6:0]  bank1;

  logic [22:0] rom5;
  logic [16:0] ram5;
  logic        we5, oe5, en5;
  logic [8:0]  bank5;

  logic [18:0] roma;
  logic [12:0] rama;
  logic        wea, oea, ena;
  logic [4:0]  banka;

  mbc_mapper #(.MODE(0), .ROM_BANK_BITS(7), .RAM_BANK_BITS(2),
               .SYNC_STAGES(S)) u1 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .bus(bus),
    .rom_addr(rom1), .ram_addr(ram1), .ram_we(we1),
    .cart_oe(oe1), .rom_bank(bank1), .ram_enabled(en1)
  );

  mbc_mapper #(.MODE(1), .ROM_BANK_BITS(9), .RAM_BANK_BITS(4),
               .SYNC_STAGES(S)) u5 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .bus(bus),
    .rom_addr(rom5), .ram_addr(ram5), .ram_we(we5),
    .cart_oe(oe5), .rom_bank(bank5), .ram_enabled(en5)
  );

  mbc_mapper #(.MODE(0), .ROM_BANK_BITS(5), .RAM_BANK_BITS(0),
               .SYNC_STAGES(S)) ua (
    .clk(clk), .reset_n(reset_n), .enable(enable), .bus(bus),
    .rom_addr(roma), .ram_addr(rama), .ram_we(wea),
    .cart_oe(oea), .rom_bank(banka), .ram_enabled(ena)
  );

  int tests;
  int fails;
  int q1[$];
  int q5[$];
  int qa[$];

  initial clk = 1'b0;
  always #25 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sb_pop(input string name, inout int q[$],
                        input logic [31:0] act);
    tests++;
    if (q.size() == 0) begin
      fails++;
      $display("FAIL %s: unexpected ram_we addr %0h expected none",
               name, act);
    end else begin
      int e;
      e = q.pop_front();
      if (act !== e) begin
        fails++;
        $display("FAIL %s: got ram_addr %0h expected %0h", name, act, e);
      end
    end
  endtask

  // Monitor: every ram_we cycle must match one queued expectation
  always @(negedge clk) begin
    if (reset_n) begin
      if (we1) sb_pop("we_mbc1", q1, {17'd0, ram1});
      if (we5) sb_pop("we_mbc5", q5, {15'd0, ram5});
      if (wea) sb_pop("we_mbc1a", qa, {19'd0, rama});
    end
  end

  task automatic bus_write(input logic [15:0] addr, input logic [7:0] dat);
    @(posedge clk); #1;
    bus.bus_A_s    = addr;
    bus.bus_D_in_s = dat;
    bus.bus_nWR    = 1'b0;
    repeat (3) @(posedge clk);
    #1 bus.bus_nWR = 1'b1;
    repeat (S + 4) @(posedge clk);
  endtask

  task automatic set_a(input logic [15:0] addr, input logic nrd);
    @(posedge clk); #1;
    bus.bus_A_s = addr;
    bus.bus_nRD = nrd;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset_n = 1'b0;
    enable = 1'b1;
    bus.bus_A_s = 16'h0000;
    bus.bus_D_in_s = 8'h00;
    bus.bus_nWR = 1'b1;
    bus.bus_nRD = 1'b1;
    repeat (3) @(posedge clk);
    #10 reset_n = 1'b1;
    repeat (100) @(posedge clk);
    @(negedge clk);
    check("rst_bank1", {25'd0, bank1}, 1);
    check("rst_bank5", {23'd0, bank5}, 1);
    check("rst_ramen", {29'd0, en1, en5, ena}, 0);
    check("rst_oe", {29'd0, oe1, oe5, oea}, 0);
    set_a(16'h4123, 1'b0);
    check("rd_4123_mbc1", {11'd0, rom1}, 32'h04123);
    check("rd_4123_mbc5", {9'd0, rom5}, 32'h04123);
    check("rd_oe", {31'd0, oe1}, 1);
    set_a(16'h4123, 1'b1);

    bus_write(16'h2100, 8'h00);
    @(negedge clk);
    check("zero_remap_mbc1", {25'd0, bank1}, 1);
    check("zero_noremap_mbc5", {23'd0, bank5}, 0);
    bus_write(16'h2100, 8'h1F);
    set_a(16'h7FFF, 1'b1);
    check("bank1f_mbc1", {25'd0, bank1}, 32'h1F);
    check("rom_7fff_mbc1", {11'd0, rom1}, 32'h7FFFF);
    check("rom_7fff_b5", {13'd0, roma}, 32'h7FFFF);
    check("rom_7fff_mbc5", {9'd0, rom5}, 32'h7FFFF);
    bus_write(16'h2000, 8'h20);
    @(negedge clk);
    check("lo5_zero_mbc1", {25'd0, bank1}, 1);
    check("bank20_mbc5", {23'd0, bank5}, 32'h20);

    bus_write(16'h4000, 8'h02);
    set_a(16'hA123, 1'b1);
    check("hi2_bank_mbc1", {25'd0, bank1}, 32'h41);
    check("hi2_trunc_b5", {27'd0, banka}, 32'h01);
    check("ram_mode0_mbc1", {17'd0, ram1}, 32'h0123);
    check("ram_rb2_mbc5", {15'd0, ram5}, 32'h4123);
    set_a(16'h0010, 1'b1);
    check("rom0_mode0_mbc1", {11'd0, rom1}, 32'h00010);
    bus_write(16'h6000, 8'h01);
    set_a(16'h0010, 1'b1);
    check("rom0_mode1_mbc1", {11'd0, rom1}, 32'h100010);
    check("rom0_mode1_b5", {13'd0, roma}, 32'h00010);
    check("rom0_mbc5", {9'd0, rom5}, 32'h00010);
    check("ram_mode1_mbc1", {17'd0, ram1}, 32'h4010);
    check("ram_mode1_mbc5", {15'd0, ram5}, 32'h4010);
    check("ram_flat", {19'd0, rama}, 32'h0010);

    bus_write(16'h2000, 8'h00);
    bus_write(16'h3000, 8'h01);
    set_a(16'h4000, 1'b1);
    check("bank100_mbc5", {23'd0, bank5}, 32'h100);
    check("rom_4000_mbc5", {9'd0, rom5}, 32'h400000);
    check("rom_4000_mbc1", {11'd0, rom1}, 32'h104000);
    bus_write(16'h3000, 8'h00);
    set_a(16'h4ABC, 1'b1);
    check("bank0_mbc5", {23'd0, bank5}, 0);
    check("rom_bank0_mbc5", {9'd0, rom5}, 32'h00ABC);

    set_a(16'hA000, 1'b0);
    check("oe_ram_off", {31'd0, oe1}, 0);
    set_a(16'hA000, 1'b1);
    bus_write(16'hA000, 8'h77);
    bus_write(16'h0000, 8'h0A);
    @(negedge clk);
    check("ramen_on", {29'd0, en1, en5, ena}, 32'h7);
    set_a(16'hA000, 1'b0);
    check("oe_ram_on", {31'd0, oe1}, 1);
    set_a(16'hC000, 1'b0);
    check("oe_c000", {31'd0, oe1}, 0);
    set_a(16'hC000, 1'b1);
    q1.push_back(32'h4005);
    q5.push_back(32'h4005);
    qa.push_back(32'h0005);
    bus_write(16'hA005, 8'h55);

    enable = 1'b0;
    bus_write(16'h2000, 8'h03);
    bus_write(16'hA001, 8'h11);
    @(negedge clk);
    check("en0_mbc1", {25'd0, bank1}, 32'h41);
    check("en0_mbc5", {23'd0, bank5}, 0);
    enable = 1'b1;

    @(posedge clk); #1;
    bus.bus_A_s = 16'h2000;
    bus.bus_D_in_s = 8'h07;
    bus.bus_nWR = 1'b0;
    repeat (3) @(posedge clk);
    #1 bus.bus_nWR = 1'b1;
    @(posedge clk);
    #5 reset_n = 1'b0;
    #1;
    check("midrst_bank1", {25'd0, bank1}, 1);
    check("midrst_bank5", {23'd0, bank5}, 1);
    check("midrst_flags", {26'd0, en1, en5, oe1, oe5, we1, we5}, 0);
    @(negedge clk);
    #10 reset_n = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("post_rst_bank1", {25'd0, bank1}, 1);
    check("post_rst_bank5", {23'd0, bank5}, 1);
    check("sb_drained", q1.size() + q5.size() + qa.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mbc_mapper.md
Name: mbc_mapper

Overview:
Parametrised memory-bank controller for the cartridge gateware, generalising the fixed 3-bit ROM-bank register into a selectable MBC1/MBC5 mapper. It adds wider ROM banking, external-RAM banking with a RAM-enable gate, and an MBC1 banking-mode bit. It sits between the synchronised cartridge bus (bus_A_s, bus_D_in_s) and the SPRAM arrays, producing ROM/RAM addresses, a RAM write strobe and the current bank for the LED driver.

Parameters:
MODE, 0, mapper type: 0 = MBC1, 1 = MBC5
ROM_BANK_BITS, 5, implemented ROM bank bits (MBC1 2..7, MBC5 2..9); ROM address width = ROM_BANK_BITS+14
RAM_BANK_BITS, 2, implemented RAM bank bits (0..2 MBC1, 0..4 MBC5); RAM address width = RAM_BANK_BITS+13
SYNC_STAGES, 4, depth of the internal bus_nWR synchroniser shift register (>=2)

Ports:
clk  in  1  system clock (20 MHz)
reset_n  in  1  asynchronous active-low reset
enable  in  1  load_done; register writes are ignored while low
bus_A_s  in  16  synchronised cartridge address
bus_D_in_s  in  8  synchronised cartridge write data
bus_nWR  in  1  raw cartridge write strobe, synchronised internally
bus_nRD  in  1  raw cartridge read strobe
rom_addr  out  ROM_BANK_BITS+14  SPRAM ROM address
ram_addr  out  RAM_BANK_BITS+13  external-RAM SPRAM address
ram_we  out  1  one-cycle RAM write pulse
cart_oe  out  1  high = cartridge drives bus_D
rom_bank  out  ROM_BANK_BITS  current switchable ROM bank (LED)
ram_enabled  out  1  RAM-enable register state

Behaviour:
- Reset (async, reset_n low): rom_bank = 1, upper/ram_bank = 0, ram_enabled = 0, mode bit = 0, ram_we = 0, cart_oe = 0, synchroniser filled with 1s. No spurious wr_edge is produced on reset release.
- Write detect: bus_nWR shifts through the SYNC_STAGES-deep register. wr_edge is a registered one-cycle pulse on a 0->1 transition between the last two stages, i.e. at the trailing edge of the write, when address and data are stable. bus_A_s and bus_D_in_s are sampled in the wr_edge cycle. All register updates take effect on the cycle after wr_edge. Every update is gated by enable.
- Register map (MODE 0, MBC1):
  - 0000-1FFF: ram_enabled <= (D[3:0] == 4'hA).
  - 2000-3FFF: lo5 <= D[4:0]. A value of 0 is stored as 1; the zero check uses all 5 bits before truncation.
  - 4000-5FFF: hi2 <= D[1:0].
  - 6000-7FFF: mode <= D[0].
  - rom_bank = {hi2, lo5} truncated to ROM_BANK_BITS.
- Register map (MODE 1, MBC5):
  - 0000-1FFF: same as MBC1.
  - 2000-2FFF: bank[7:0] <= D.
  - 3000-3FFF: bank[8] <= D[0].
  - 4000-5FFF: ram_bank <= D[3:0].
  - No zero remap; bank 0 is selectable at 4000-7FFF.
  - rom_bank truncated to ROM_BANK_BITS.
- ROM address (combinational from bus_A_s and registers):
  - A[15:14] == 00: bank field = 0. In MBC1 with mode = 1, the bank field is instead {hi2, 5'b0}, truncated.
  - A[15:14] == 01: bank field = rom_bank.
  - rom_addr = {bank field, A[13:0]}.
- RAM address: ram_addr = {rbank, A[12:0]}.
  - MBC1: rbank = mode ? hi2 : 0.
  - MBC5: rbank = ram_bank.
  - rbank is truncated to RAM_BANK_BITS; with RAM_BANK_BITS = 0 there is no bank field.
- ram_we: registered pulse, exactly one cycle, asserted the cycle after wr_edge when A[15:13] == 3'b101, ram_enabled = 1 and enable = 1.
- cart_oe: registered. Asserted when bus_nRD = 0 and either A[15] = 0, or A[15:13] == 101 with ram_enabled = 1. Otherwise 0, so reads of disabled RAM float the bus.
- Simultaneous events: a wr_edge targeting 0000-1FFF updates only ram_enabled. A RAM write in the same cycle as a RAM-disable is impossible (single address). The new bank applies to accesses starting the cycle after the update.
- Reset mid-write: all state clears asynchronously. A pending edge is discarded because the synchroniser reloads with 1s.

Test Plan:
1. Reset release with bus idle (nWR = 1) -> rom_bank = 1, ram_enabled = 0, no ram_we pulse over 100 cycles; read of A = 4123 gives rom_addr = 0x04123.
2. MBC1: write 0x00 to 2100 -> rom_bank = 1. Write 0x1F -> rom_bank = 0x1F. A = 7FFF gives rom_addr = 0x7FFFF (ROM_BANK_BITS = 5).
3. MBC1, ROM_BANK_BITS = 7: write hi2 = 2 at 4000, mode = 1 at 6000 -> A = 0010 gives rom_addr = 0x100010, and ram_addr uses bank 2.
4. MBC5, ROM_BANK_BITS = 9: write 0x00 at 2000 and 0x01 at 3000 -> rom_bank = 0x100. Write 0x00 at 3000 -> rom_bank = 0 (no remap).
5. RAM gate: write to A000 with ram_enabled = 0 -> no ram_we, cart_oe = 0 on read. Write 0x0A at 0000, then write 0x55 at A005 -> single one-cycle ram_we with ram_addr = {bank, 0x0005}.
6. enable = 0: write 0x03 at 2000 -> rom_bank stays 1. Assert reset_n low mid-write -> all registers return to reset values immediately.
